// File: rtl/seq_mult_32bit.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier; 32 cycles from accepted start to done.
// Backpressure: start is ignored while busy; the next start can be taken during the done cycle.

module cla_32bit (
    input  logic [31:0] ain,
    input  logic [31:0] bin,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;
    logic [8:0]  w_cg;

    assign w_g     = ain & bin;
    assign w_p     = ain ^ bin;
    assign w_cg[0] = cin;

    // 4-bit lookahead groups; group carries chain between groups
    for (genvar k = 0; k < 8; k++) begin : g_grp
        localparam int B = 4 * k;
        logic w_gg;
        logic w_gp;

        assign w_c[B]   = w_cg[k];
        assign w_c[B+1] = w_g[B] | (w_p[B] & w_cg[k]);
        assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                        | (w_p[B+1] & w_p[B] & w_cg[k]);
        assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                        | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_cg[k]);
        assign w_gg     = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                        | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
        assign w_gp     = w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B];
        assign w_cg[k+1] = w_gg | (w_gp & w_cg[k]);
    end

    assign w_c[32] = w_cg[8];
    assign sum     = w_p ^ w_c[31:0];
    assign cout    = w_c[32];
endmodule

module seq_mult_32bit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     ain,
    input  logic [WIDTH-1:0]     bin,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_m;
    logic [63:0] r_p;
    logic [4:0]  r_cnt;
    logic [63:0] r_product;

    logic [31:0] w_addend;
    logic [31:0] w_sum;
    logic        w_cout;
    logic [63:0] w_p_next;

    assign w_addend = r_p[0] ? r_m : 32'h0;

    cla_32bit u_cla (
        .ain  (r_p[63:32]),
        .bin  (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // carry-out lands in bit 63 so the shifted accumulator never overflows
    assign w_p_next = {w_cout, w_sum, r_p[31:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_m       <= 32'h0;
            r_p       <= 64'h0;
            r_cnt     <= 5'd0;
            r_product <= 64'h0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_m     <= ain;
                        r_p     <= {32'h0, bin};
                        r_cnt   <= 5'd0;
                        r_state <= CALC;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_product <= w_p_next;
                        r_state   <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = (r_state == CALC);
    assign done    = (r_state == DONE);
    assign product = r_product;
endmodule

// File: doc/seq_mult_32bit.md
Name: seq_mult_32bit

Overview:
Sequential unsigned 32x32 -> 64-bit shift-and-add multiplier. It sits directly downstream of the operand source and consumes the cla_32bit adder: one cla_32bit instance performs every partial-product accumulation. The block takes one iteration per clock, has a start/busy/done handshake, and holds the 64-bit result until the next operation.

Parameters:
WIDTH, 32, operand width. Only 32 is supported because the datapath instantiates cla_32bit. The product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a multiply; sampled on the rising edge of clk
ain  input  32  multiplicand; latched on an accepted start
bin  input  32  multiplier; latched on an accepted start
busy  output  1  high while iterating
done  output  1  single-cycle pulse when product becomes valid
product  output  64  registered result; held until the next completion

Behaviour:
- Reset (rst_n low, asynchronous, dominates all inputs):
  - state goes to IDLE.
  - busy=0, done=0, product=0.
  - Internal registers M, P and cnt clear to 0.
- States: IDLE, CALC, DONE.
- Internal registers:
  - M[31:0]: latched multiplicand.
  - P[63:0]: accumulator/multiplier shift register.
  - cnt[4:0]: iteration counter.
- Start acceptance: start=1 at a clk edge in IDLE or DONE performs the following, then the state goes to CALC:
  - M <= ain
  - P <= {32'h0, bin}
  - cnt <= 0
- start is ignored in CALC. There is no queueing, and ain/bin changes during CALC have no effect.
- CALC iteration, once per edge:
  - Adder inputs: ain=P[63:32], bin=(P[0] ? M : 32'h0), cin=0. This gives sum and cout.
  - Update: P <= {cout, sum, P[31:1]}, a logical right shift of the 65-bit {cout, upper, lower}.
  - cnt <= cnt+1.
  - On the edge where cnt==31 (the 32nd iteration):
    - product <= the updated P value.
    - State goes to DONE.
- DONE lasts exactly one cycle, with done=1.
  - Next state: CALC if start=1 at that edge (back-to-back accepted), else IDLE.
- busy = (state==CALC), decoded from the registered state with no combinational path from start.
- done = (state==DONE). It is never high in two consecutive cycles.
- Latency: if start is sampled at edge E0, iterations occur at E1..E32. done and the new product are visible from E32 until E33. The next start can be sampled at E33, which is the DONE cycle.
- product changes only on the completing edge or on reset. It is stable through IDLE, CALC of the next operation, and DONE.
- Arithmetic:
  - Unsigned only.
  - The adder carry-out is kept in bit 63 before shifting, so no overflow is possible. The full 64-bit product is exact for all operands.
- Reset mid-operation: the operation is abandoned immediately. Outputs go to their reset values, and the first start after rst_n deasserts begins a fresh operation.
- Zero operands need no early termination. All 32 iterations always run, giving a fixed latency.

Test Plan:
- Basic: reset, then start with ain=3, bin=5 -> busy high for 32 cycles, done pulses once 32 edges after the start edge, product=64'h0000_0000_0000_000F.
- Maximum operands: ain=32'hFFFF_FFFF, bin=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001. Checks the carry-out capture into bit 63.
- Carry/shift: ain=32'h8000_0000, bin=2 -> product=64'h0000_0001_0000_0000. ain=0, bin=32'h1234_5678 -> product=0 with the same 32-cycle latency.
- Start while busy: start with ain=7, bin=6, then pulse start with ain=9, bin=9 at cycle 10 -> ignored. The result is 42, done pulses exactly once, and the state returns to IDLE.
- Back-to-back: hold start high continuously with ain=2, bin=3, then change to ain=4, bin=5 during the first DONE cycle -> product 6, then exactly 33 cycles later product 20. done pulses are separated by 33 cycles, and busy goes low only during DONE.
- Reset mid-operation: assert rst_n=0 asynchronously at iteration 15 of ain=100, bin=100 -> busy, done and product go to 0 immediately, without waiting for a clock edge. A subsequent start with ain=100, bin=100 yields product 10000 with full latency.
